load_data_ctrl: RTL and testbench
=================================

# load_data_ctrl

Sequencer for the load-data path. It accepts segment requests (`pointer`, `data_len`) and turns each one into one or two read beats to the data buffer, each carrying a buffer row address, an in-row begin index and a length. A second beat is produced only when the segment crosses a `DATA_READ_WIDTH` row boundary. The block sits between the request source (pointer/length decode) and the data buffer read port and lane extractor, and it owns the read-stall decision.

## Interface
- `DATA_READ_WIDTH`, 32, elements per buffer row; must be a power of two.
- `POINTER_WIDTH`, 30, element pointer width.
- `ADDR_WIDTH`, 21, buffer row address width.
- `LEN_WIDTH`, 11, length/index width.
- `clk` input 1: single clock.
- `rst` input 1: reset, asynchronous, active-high.
- `ena` input 1: global enable; when low the block freezes.
- `req_valid` input 1: request valid.
- `req_ready` output 1: request accepted when `req_valid & req_ready`.
- `req_pointer` input POINTER_WIDTH: segment start, in elements.
- `req_len` input LEN_WIDTH: segment length, in elements.
- `out_valid` output 1: beat descriptor valid.
- `out_ready` input 1: consumer accepts the beat.
- `out_begin` output LEN_WIDTH: first element index within the row.
- `out_len` output LEN_WIDTH: number of elements taken from the row.
- `out_last` output 1: final beat of the request.
- `rd_en` output 1: buffer read strobe, equal to `out_valid & out_ready & ena`.
- `rd_addr` output ADDR_WIDTH: buffer row address of the current beat.
- `err` output 1: one-cycle pulse when an illegal request is accepted.
- `stat_req_cnt` output 32: accepted requests (see Configuration).
- `stat_split_cnt` output 32: accepted requests that needed two beats.

## Operation
- States: `IDLE`, `BEAT0`, `BEAT1`.
- On acceptance the block registers:
  - `addr = pointer >> log2(DATA_READ_WIDTH)`, truncated to ADDR_WIDTH.
  - `begin = pointer & (DATA_READ_WIDTH-1)`.
  - `end = begin + len`, computed in LEN_WIDTH+1 bits.
  - `split = end > DATA_READ_WIDTH` (strictly greater).
- `BEAT0` drives `rd_addr=addr` and `out_begin=begin`.
  - If split: `out_len = DATA_READ_WIDTH - begin`, `out_last=0`.
  - If not split: `out_len = len`, `out_last=1`.
- `BEAT1` drives `rd_addr = addr+1` (wraps modulo 2^ADDR_WIDTH), `out_begin=0`, `out_len = end - DATA_READ_WIDTH`, `out_last=1`.
- Transitions:
  - `IDLE` to `BEAT0` on a legal accept.
  - `BEAT0` to `BEAT1` on `out_ready` if split.
  - `BEAT0` or `BEAT1` (on the last beat) to `BEAT0` if a new legal request is accepted in the same cycle, otherwise to `IDLE`.
- `req_ready = ena & (state==IDLE | (out_last & out_valid & out_ready))`. This gives back-to-back acceptance.
- Illegal request: `req_len > DATA_READ_WIDTH`.
  - It is accepted and `err` pulses the next cycle.
  - No beat is produced and the state returns to or stays in `IDLE`.
- `req_len == 0` is legal: one beat with `out_len=0`, `out_last=1`, and `rd_en` still issued.
- `ena` low: state, registers and outputs hold; `req_ready=0`; `rd_en=0`; `out_valid` keeps its value.
- Descriptor outputs stay stable while `out_valid & !out_ready`.

## Timing
- Reset values: state `IDLE`, `out_valid=0`, `out_begin=0`, `out_len=0`, `out_last=0`, `rd_addr=0`, `err=0`, both stat counters 0. `req_ready` is 1 once `rst` is low and `ena` is high.
- Asserting `rst` mid-beat clears everything immediately (asynchronously), and the in-flight request is dropped.
- Latency: request accepted at cycle N, `out_valid` at N+1.
- Throughput with `out_ready` held high:
  - 1 request per cycle for non-split requests.
  - 2 cycles per request for split requests.
- `rd_en` is combinational from `out_ready`. Buffer data returns with the buffer's own latency; this block does not track it.
- `err` is registered, high for exactly one cycle.

## Configuration
- `LOAD_DATA_CTRL_STATS_EN` defined:
  - `stat_req_cnt` increments on each legal accept.
  - `stat_split_cnt` increments on each accept with split=1.
  - Both are 32-bit, wrap at 2^32, and are cleared by `rst`.
- Undefined: both ports remain and are tied to 0, and no counter logic is built.

## Structure
- Shared package `load_data_pkg`:
  - state enum `load_ctrl_state_t`.
  - `LOAD_DATA_READ_WIDTH`, `LOAD_LEN_WIDTH`, `LOAD_ADDR_WIDTH` constants.
  - descriptor struct `load_beat_t` (addr, begin, len, last).
- One sub-module: `load_data_beat_calc`, a purely combinational block that computes addr/begin/end/split/illegal from pointer and len. It is instantiated once on the request side.

## Test plan
- W=32: ptr=70, len=10 -> one beat: `rd_addr=2`, `out_begin=6`, `out_len=10`, `out_last=1`.
- ptr=60, len=10 -> two beats:
  - beat 0: addr 1, begin 28, len 4, last 0.
  - beat 1: addr 2, begin 0, len 6, last 1.
  - `stat_split_cnt=1` with `LOAD_DATA_CTRL_STATS_EN` defined.
- ptr=48, len=16 (end == 32) -> single beat: addr 1, begin 16, len 16, last 1. No split.
- len=40 -> accepted, `err` high for one cycle, no `out_valid`, `req_ready` high again the next cycle.
- Split request with `out_ready` low for 3 cycles in `BEAT0` -> descriptor held and `rd_en=0`. Then `rst` pulsed during `BEAT1` -> `out_valid=0` immediately, state `IDLE`.
- Four non-split requests back-to-back with `out_ready=1` -> four consecutive beats, `req_ready` continuously high, `stat_req_cnt=4`.

Source files
------------

// File: rtl/load_data_pkg.sv
// Shared types and constants for the load-data sequencer: state encoding,
// default geometry and the beat descriptor carried to the buffer read port.
package load_data_pkg;

   localparam int LOAD_DATA_READ_WIDTH = 32;
   localparam int LOAD_POINTER_WIDTH   = 30;
   localparam int LOAD_ADDR_WIDTH      = 21;
   localparam int LOAD_LEN_WIDTH       = 11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2
   } load_ctrl_state_t;

   typedef struct packed {
      logic [LOAD_ADDR_WIDTH-1:0] addr;
      logic [LOAD_LEN_WIDTH-1:0]  beg_idx;
      logic [LOAD_LEN_WIDTH-1:0]  len;
      logic                       last;
   } load_beat_t;

endpackage

// File: rtl/load_data_beat_calc.sv
// Combinational segment decode: row address, in-row begin, end index,
// row-crossing (split) and illegal-length flags from pointer and length.
module load_data_beat_calc
   import load_data_pkg::*;
#(
   parameter int DATA_READ_WIDTH = LOAD_DATA_READ_WIDTH,
   parameter int POINTER_WIDTH   = LOAD_POINTER_WIDTH,
   parameter int ADDR_WIDTH      = LOAD_ADDR_WIDTH,
   parameter int LEN_WIDTH       = LOAD_LEN_WIDTH
) (
   input  logic [POINTER_WIDTH-1:0] i_pointer,
   input  logic [LEN_WIDTH-1:0]     i_len,
   output logic [ADDR_WIDTH-1:0]    o_addr,
   output logic [LEN_WIDTH-1:0]     o_begin,
   output logic [LEN_WIDTH:0]       o_end,
   output logic                     o_split,
   output logic                     o_illegal
);

   localparam int SHIFT = $clog2(DATA_READ_WIDTH);

   logic [POINTER_WIDTH-1:0] w_row;

   assign w_row     = i_pointer >> SHIFT;
   assign o_addr    = w_row[ADDR_WIDTH-1:0];
   assign o_begin   = i_pointer[LEN_WIDTH-1:0] & LEN_WIDTH'(DATA_READ_WIDTH - 1);
   // One extra bit so begin+len never wraps before the split compare.
   assign o_end     = {1'b0, o_begin} + {1'b0, i_len};
   assign o_split   = o_end > (LEN_WIDTH+1)'(DATA_READ_WIDTH);
   assign o_illegal = i_len > LEN_WIDTH'(DATA_READ_WIDTH);

endmodule

// File: rtl/load_data_ctrl.sv
// Load-data sequencer: turns (pointer, len) requests into one or two buffer
// read beats. Optional counters enabled by LOAD_DATA_CTRL_STATS_EN.
module load_data_ctrl
   import load_data_pkg::*;
#(
   parameter int DATA_READ_WIDTH = LOAD_DATA_READ_WIDTH,
   parameter int POINTER_WIDTH   = LOAD_POINTER_WIDTH,
   parameter int ADDR_WIDTH      = LOAD_ADDR_WIDTH,
   parameter int LEN_WIDTH       = LOAD_LEN_WIDTH
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_ena,
   input  logic                     i_req_valid,
   output logic                     o_req_ready,
   input  logic [POINTER_WIDTH-1:0] i_req_pointer,
   input  logic [LEN_WIDTH-1:0]     i_req_len,
   output logic                     o_out_valid,
   input  logic                     i_out_ready,
   output logic [LEN_WIDTH-1:0]     o_out_begin,
   output logic [LEN_WIDTH-1:0]     o_out_len,
   output logic                     o_out_last,
   output logic                     o_rd_en,
   output logic [ADDR_WIDTH-1:0]    o_rd_addr,
   output logic                     o_err,
   output logic [31:0]              o_stat_req_cnt,
   output logic [31:0]              o_stat_split_cnt
);

   load_ctrl_state_t r_state, w_state_nxt;

   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LEN_WIDTH-1:0]  r_begin, r_len;
   logic [LEN_WIDTH:0]    r_end;
   logic                  r_split, r_err;

   logic [ADDR_WIDTH-1:0] w_addr;
   logic [LEN_WIDTH-1:0]  w_begin;
   logic [LEN_WIDTH:0]    w_end;
   logic                  w_split, w_illegal;
   logic                  w_out_valid, w_req_ready, w_accept, w_load, w_adv;
   load_beat_t            w_beat;

   load_data_beat_calc #(
      .DATA_READ_WIDTH (DATA_READ_WIDTH),
      .POINTER_WIDTH   (POINTER_WIDTH),
      .ADDR_WIDTH      (ADDR_WIDTH),
      .LEN_WIDTH       (LEN_WIDTH)
   ) u_calc (
      .i_pointer (i_req_pointer),
      .i_len     (i_req_len),
      .o_addr    (w_addr),
      .o_begin   (w_begin),
      .o_end     (w_end),
      .o_split   (w_split),
      .o_illegal (w_illegal)
   );

   assign w_out_valid = (r_state != IDLE);

   always_comb begin
      w_beat = '0;
      case (r_state)
         BEAT0: begin
            w_beat.addr    = r_addr;
            w_beat.beg_idx = r_begin;
            w_beat.len     = r_split ? (LEN_WIDTH'(DATA_READ_WIDTH) - r_begin) : r_len;
            w_beat.last    = ~r_split;
         end
         BEAT1: begin
            w_beat.addr    = r_addr + 1'b1;
            w_beat.beg_idx = '0;
            w_beat.len     = LEN_WIDTH'(r_end - (LEN_WIDTH+1)'(DATA_READ_WIDTH));
            w_beat.last    = 1'b1;
         end
         default: w_beat = '0;
      endcase
   end

   // Ready re-opens on the last beat's handshake so requests stream back-to-back.
   assign w_adv       = i_ena & i_out_ready & w_out_valid;
   assign w_req_ready = i_ena & ((r_state == IDLE) | (w_beat.last & w_adv));
   assign w_accept    = i_req_valid & w_req_ready;
   assign w_load      = w_accept & ~w_illegal;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:  if (w_load) w_state_nxt = BEAT0;
         BEAT0: if (w_adv)  w_state_nxt = r_split ? BEAT1 : (w_load ? BEAT0 : IDLE);
         BEAT1: if (w_adv)  w_state_nxt = w_load ? BEAT0 : IDLE;
         default:           w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_begin <= '0;
         r_len   <= '0;
         r_end   <= '0;
         r_split <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= w_accept & w_illegal;
         if (w_load) begin
            r_addr  <= w_addr;
            r_begin <= w_begin;
            r_len   <= i_req_len;
            r_end   <= w_end;
            r_split <= w_split;
         end
      end
   end

`ifdef LOAD_DATA_CTRL_STATS_EN
   logic [31:0] r_req_cnt, r_split_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_req_cnt   <= '0;
         r_split_cnt <= '0;
      end else if (w_load) begin
         r_req_cnt <= r_req_cnt + 32'd1;
         if (w_split) r_split_cnt <= r_split_cnt + 32'd1;
      end
   end

   assign o_stat_req_cnt   = r_req_cnt;
   assign o_stat_split_cnt = r_split_cnt;
`else
   assign o_stat_req_cnt   = '0;
   assign o_stat_split_cnt = '0;
`endif

   assign o_req_ready = w_req_ready;
   assign o_out_valid = w_out_valid;
   assign o_out_begin = w_beat.beg_idx;
   assign o_out_len   = w_beat.len;
   assign o_out_last  = w_beat.last;
   assign o_rd_addr   = w_beat.addr;
   assign o_rd_en     = w_adv;
   assign o_err       = r_err;

endmodule

// File: tb/tb_load_data_ctrl.sv
// Scoreboard bench for load_data_ctrl: accepted requests expand into expected
// beats in a queue; a negedge monitor checks handshakes, descriptors and err.
module tb_load_data_ctrl;

   localparam int W = 32, PW = 30, AW = 21, LW = 11;

   logic          clk = 1'b0, rst = 1'b1, ena = 1'b0, req_valid = 1'b0, out_ready = 1'b0;
   logic [PW-1:0] req_pointer = '0;
   logic [LW-1:0] req_len = '0;
   logic          o_req_ready, o_out_valid, o_out_last, o_rd_en, o_err;
   logic [LW-1:0] o_out_begin, o_out_len;
   logic [AW-1:0] o_rd_addr;
   logic [31:0]   o_stat_req_cnt, o_stat_split_cnt;

   load_data_ctrl dut (
      .i_clk(clk), .i_rst(rst), .i_ena(ena),
      .i_req_valid(req_valid), .o_req_ready(o_req_ready),
      .i_req_pointer(req_pointer), .i_req_len(req_len),
      .o_out_valid(o_out_valid), .i_out_ready(out_ready),
      .o_out_begin(o_out_begin), .o_out_len(o_out_len), .o_out_last(o_out_last),
      .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .o_err(o_err),
      .o_stat_req_cnt(o_stat_req_cnt), .o_stat_split_cnt(o_stat_split_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint addr;
      longint beg;
      longint len;
      longint last;
   } beat_t;

   beat_t       q[$];
   int          checks = 0, errors = 0;
   bit          err_pend = 1'b0, rnd = 1'b0;
   longint      m_req = 0, m_split = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: split a segment into row-sized pieces with plain arithmetic.
   task automatic model_accept(input longint ptr, input longint len);
      longint row, beg;
      beat_t  b;
      if (len > W) begin
         err_pend = 1'b1;
         return;
      end
      row = (ptr / W) % (64'd1 << AW);
      beg = ptr % W;
      m_req++;
      if (beg + len > W) begin
         m_split++;
         b.addr = row; b.beg = beg; b.len = W - beg; b.last = 0; q.push_back(b);
         b.addr = (row + 1) % (64'd1 << AW); b.beg = 0; b.len = beg + len - W; b.last = 1;
         q.push_back(b);
      end else begin
         b.addr = row; b.beg = beg; b.len = len; b.last = 1; q.push_back(b);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         err_pend = 1'b0;
         m_req = 0;
         m_split = 0;
      end else begin
         chk("out_valid", o_out_valid, q.size() > 0);
         chk("req_ready", o_req_ready, ena && (q.size() == 0 || (q.size() == 1 && out_ready)));
         chk("rd_en", o_rd_en, ena && q.size() > 0 && out_ready);
         chk("err", o_err, err_pend);
`ifdef LOAD_DATA_CTRL_STATS_EN
         chk("stat_req_cnt", o_stat_req_cnt, m_req);
         chk("stat_split_cnt", o_stat_split_cnt, m_split);
`else
         chk("stat_req_cnt", o_stat_req_cnt, 0);
         chk("stat_split_cnt", o_stat_split_cnt, 0);
`endif
         if (q.size() > 0 && o_out_valid) begin
            chk("rd_addr", o_rd_addr, q[0].addr);
            chk("out_begin", o_out_begin, q[0].beg);
            chk("out_len", o_out_len, q[0].len);
            chk("out_last", o_out_last, q[0].last);
         end
         if (ena && out_ready && q.size() > 0) void'(q.pop_front());
         err_pend = 1'b0;
         if (req_valid && o_req_ready) model_accept(req_pointer, req_len);
      end
   end

   task automatic rand_ctl();
      if (rnd) begin
         out_ready = ($urandom % 3) != 0;
         ena       = ($urandom % 6) != 0;
      end
   endtask

   task automatic send(input longint p, input longint l);
      int n = 0;
      req_valid   = 1'b1;
      req_pointer = PW'(p);
      req_len     = LW'(l);
      forever begin
         @(negedge clk);
         if (o_req_ready) break;
         n++;
         if (n > 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout ptr %0d len %0d not accepted in 200 cycles", p, l);
            break;
         end
         @(posedge clk); #1;
         rand_ctl();
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      rand_ctl();
   endtask

   initial begin
      #12;
      chk("rst_out_valid", o_out_valid, 0);
      chk("rst_out_begin", o_out_begin, 0);
      chk("rst_out_len", o_out_len, 0);
      chk("rst_out_last", o_out_last, 0);
      chk("rst_rd_addr", o_rd_addr, 0);
      chk("rst_err", o_err, 0);
      chk("rst_stat_req", o_stat_req_cnt, 0);
      chk("rst_stat_split", o_stat_split_cnt, 0);
      @(posedge clk); #1;
      rst = 1'b0; ena = 1'b1; out_ready = 1'b1;
      #1 chk("ready_after_rst", o_req_ready, 1);

      send(70, 10);
      send(60, 10);
      send(48, 16);
      send(0, 40);
      send(5, 0);
      send(31, 32);
      send(0, 4);
      send(32, 8);
      send(64, 1);
      send(100, 20);
      repeat (3) @(posedge clk);
      #1;

      // Stall a split request in its first beat, then reset during the second.
      out_ready = 1'b0;
      send(60, 10);
      repeat (3) @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("beat1_valid", o_out_valid, 1);
      chk("beat1_addr", o_rd_addr, 2);
      #2 rst = 1'b1;
      #1;
      chk("midrst_out_valid", o_out_valid, 0);
      chk("midrst_rd_addr", o_rd_addr, 0);
      chk("midrst_out_len", o_out_len, 0);
      chk("midrst_out_last", o_out_last, 0);
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;

      rnd = 1'b1;
      for (int i = 0; i < 300; i++) begin
         longint p, l;
         p = longint'($urandom) & ((64'd1 << PW) - 1);
         if (i % 4 == 0) p = (64'd1 << PW) - 1 - longint'($urandom_range(0, 40));
         l = longint'($urandom_range(0, 42));
         if ($urandom % 4 == 0) begin
            @(posedge clk); #1;
            rand_ctl();
         end
         send(p, l);
      end
      rnd = 1'b0; ena = 1'b1; out_ready = 1'b1;
      begin
         int n = 0;
         while (q.size() > 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
         end
      end
      @(negedge clk); #1;
      chk("drain_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
